// File: rtl/draw_board.sv
// draw_board: settled-block playfield for the falling-block game.
// Holds a COLS x ROWS occupancy map, overlays occupied cells onto the
// background pixel stream with a fixed two-cycle latency, and removes
// full rows during vertical blanking.
module draw_board #(
  parameter int          BOARD_X   = 352,
  parameter int          BOARD_Y   = 64,
  parameter int          CELL_LOG2 = 5,
  parameter int          COLS      = 10,
  parameter int          ROWS      = 20,
  parameter logic [11:0] CELL_RGB  = 12'hF80,
  parameter logic [11:0] EDGE_RGB  = 12'h444
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        set_en,
  input  logic [3:0]  set_col,
  input  logic [4:0]  set_row,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        clr_busy,
  output logic [7:0]  lines_cleared
);

  localparam int          CELL_PX    = 1 << CELL_LOG2;
  localparam logic [11:0] X_LO_C     = 12'(BOARD_X);
  localparam logic [11:0] X_HI_C     = 12'(BOARD_X + COLS * CELL_PX);
  localparam logic [11:0] Y_LO_C     = 12'(BOARD_Y);
  localparam logic [11:0] Y_HI_C     = 12'(BOARD_Y + ROWS * CELL_PX);
  localparam logic [4:0]  COLS_C     = 5'(COLS);
  localparam logic [5:0]  ROWS_C     = 6'(ROWS);
  localparam logic [4:0]  LAST_ROW_C = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // A row is complete when every one of its cells is occupied.
  function automatic logic row_full(input logic [COLS-1:0] word);
    return &word;
  endfunction

  // Occupancy of one column within a zero-padded row word.
  function automatic logic cell_hit(input logic [15:0] word, input logic [3:0] col);
    return word[col];
  endfunction

  // Playfield storage and its next value
  logic [COLS-1:0] board_r     [ROWS];
  logic [COLS-1:0] board_nxt_s [ROWS];

  // Line-clear FSM
  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  scan_row_r;
  logic [4:0]  scan_row_nxt_s;
  logic        vblnk_prev_r;
  logic        vblnk_rise_s;
  logic        clr_busy_r;
  logic        clr_busy_nxt_s;
  logic [7:0]  lines_r;
  logic [7:0]  lines_nxt_s;
  logic        write_ok_s;

  // Render stage 1
  logic [10:0]          hdiff_s;
  logic [10:0]          vdiff_s;
  logic                 inside_s;
  logic [3:0]           col_s;
  logic [4:0]           row_s;
  logic [15:0]          row_word_s;
  logic [10:0]          hcount_d1_r;
  logic [10:0]          vcount_d1_r;
  logic                 hsync_d1_r;
  logic                 vsync_d1_r;
  logic                 hblnk_d1_r;
  logic                 vblnk_d1_r;
  logic [11:0]          rgb_d1_r;
  logic                 inside_r;
  logic [15:0]          row_word_r;
  logic [3:0]           col_r;
  logic [CELL_LOG2-1:0] xoff_r;
  logic [CELL_LOG2-1:0] yoff_r;

  // Render stage 2
  logic [11:0] rgb_nxt_s;
  logic [10:0] hcount_d2_r;
  logic [10:0] vcount_d2_r;
  logic        hsync_d2_r;
  logic        vsync_d2_r;
  logic        hblnk_d2_r;
  logic        vblnk_d2_r;
  logic [11:0] rgb_d2_r;

  // High difference bits only matter outside the board, where inside_s masks them.
  logic unused_diff_s;

  assign hdiff_s       = hcount_in - 11'(BOARD_X);
  assign vdiff_s       = vcount_in - 11'(BOARD_Y);
  assign col_s         = hdiff_s[CELL_LOG2+3:CELL_LOG2];
  assign row_s         = vdiff_s[CELL_LOG2+4:CELL_LOG2];
  assign unused_diff_s = ^{hdiff_s[10:CELL_LOG2+4], vdiff_s[10:CELL_LOG2+5]};
  assign inside_s      = ({1'b0, hcount_in} >= X_LO_C) && ({1'b0, hcount_in} < X_HI_C) &&
                         ({1'b0, vcount_in} >= Y_LO_C) && ({1'b0, vcount_in} < Y_HI_C);
  assign vblnk_rise_s  = vblnk_in & ~vblnk_prev_r;
  assign write_ok_s    = set_en && (state_r == ST_IDLE) &&
                         ({1'b0, set_col} < COLS_C) && ({1'b0, set_row} < ROWS_C);

  // Fetch the playfield row under the current pixel, zero when off-board.
  always_comb begin
    if (inside_s && ({1'b0, row_s} < ROWS_C)) begin
      row_word_s = 16'(board_r[row_s]);
    end else begin
      row_word_s = 16'h0000;
    end
  end

  // Stage 1: delay timing and capture the addressed row word and cell offsets.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_d1_r <= 11'd0;
      vcount_d1_r <= 11'd0;
      hsync_d1_r  <= 1'b0;
      vsync_d1_r  <= 1'b0;
      hblnk_d1_r  <= 1'b0;
      vblnk_d1_r  <= 1'b0;
      rgb_d1_r    <= 12'h000;
      inside_r    <= 1'b0;
      row_word_r  <= 16'h0000;
      col_r       <= 4'd0;
      xoff_r      <= {CELL_LOG2{1'b0}};
      yoff_r      <= {CELL_LOG2{1'b0}};
    end else begin
      hcount_d1_r <= hcount_in;
      vcount_d1_r <= vcount_in;
      hsync_d1_r  <= hsync_in;
      vsync_d1_r  <= vsync_in;
      hblnk_d1_r  <= hblnk_in;
      vblnk_d1_r  <= vblnk_in;
      rgb_d1_r    <= rgb_in;
      inside_r    <= inside_s;
      row_word_r  <= row_word_s;
      col_r       <= col_s;
      xoff_r      <= hdiff_s[CELL_LOG2-1:0];
      yoff_r      <= vdiff_s[CELL_LOG2-1:0];
    end
  end

  // Composite colour: blanking wins, then occupied cells with a bevelled top/left edge.
  always_comb begin
    if (hblnk_d1_r || vblnk_d1_r) begin
      rgb_nxt_s = 12'h000;
    end else if (inside_r && cell_hit(row_word_r, col_r)) begin
      if ((xoff_r == {CELL_LOG2{1'b0}}) || (yoff_r == {CELL_LOG2{1'b0}})) begin
        rgb_nxt_s = EDGE_RGB;
      end else begin
        rgb_nxt_s = CELL_RGB;
      end
    end else begin
      rgb_nxt_s = rgb_d1_r;
    end
  end

  // Stage 2: register every pixel-path output.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_d2_r <= 11'd0;
      vcount_d2_r <= 11'd0;
      hsync_d2_r  <= 1'b0;
      vsync_d2_r  <= 1'b0;
      hblnk_d2_r  <= 1'b0;
      vblnk_d2_r  <= 1'b0;
      rgb_d2_r    <= 12'h000;
    end else begin
      hcount_d2_r <= hcount_d1_r;
      vcount_d2_r <= vcount_d1_r;
      hsync_d2_r  <= hsync_d1_r;
      vsync_d2_r  <= vsync_d1_r;
      hblnk_d2_r  <= hblnk_d1_r;
      vblnk_d2_r  <= vblnk_d1_r;
      rgb_d2_r    <= rgb_nxt_s;
    end
  end

  // Playfield next value: collapse rows during SHIFT, otherwise accept a legal write.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      board_nxt_s[i] = board_r[i];
    end
    if (state_r == ST_SHIFT) begin
      board_nxt_s[0] = {COLS{1'b0}};
      for (int i = 1; i < ROWS; i++) begin
        if (5'(i) <= scan_row_r) begin
          board_nxt_s[i] = board_r[i-1];
        end else begin
          board_nxt_s[i] = board_r[i];
        end
      end
    end else if (write_ok_s) begin
      board_nxt_s[set_row][set_col] = 1'b1;
    end else begin
      board_nxt_s[0] = board_r[0];
    end
  end

  // Playfield register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        board_r[i] <= {COLS{1'b0}};
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        board_r[i] <= board_nxt_s[i];
      end
    end
  end

  // Line-clear FSM state register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      scan_row_r <= 5'd0;
    end else begin
      state_r    <= state_nxt_s;
      scan_row_r <= scan_row_nxt_s;
    end
  end

  // Line-clear FSM next state: scan bottom-up, re-check a row after each shift.
  always_comb begin
    state_nxt_s    = state_r;
    scan_row_nxt_s = scan_row_r;
    case (state_r)
      ST_IDLE: begin
        if (vblnk_rise_s) begin
          state_nxt_s    = ST_SCAN;
          scan_row_nxt_s = LAST_ROW_C;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (row_full(board_r[scan_row_r])) begin
          state_nxt_s    = ST_SHIFT;
        end else if (scan_row_r == 5'd0) begin
          state_nxt_s    = ST_IDLE;
        end else begin
          scan_row_nxt_s = scan_row_r - 5'd1;
        end
      end
      ST_SHIFT: begin
        state_nxt_s = ST_SCAN;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        scan_row_nxt_s = 5'd0;
      end
    endcase
  end

  // Line-clear FSM outputs: busy follows the next state, count bumps on each shift.
  always_comb begin
    clr_busy_nxt_s = (state_nxt_s != ST_IDLE);
    if (state_r == ST_SHIFT) begin
      lines_nxt_s = lines_r + 8'd1;
    end else begin
      lines_nxt_s = lines_r;
    end
  end

  // Registered FSM outputs and vblank edge history.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      clr_busy_r   <= 1'b0;
      lines_r      <= 8'd0;
      vblnk_prev_r <= 1'b0;
    end else begin
      clr_busy_r   <= clr_busy_nxt_s;
      lines_r      <= lines_nxt_s;
      vblnk_prev_r <= vblnk_in;
    end
  end

  assign hcount_out    = hcount_d2_r;
  assign vcount_out    = vcount_d2_r;
  assign hsync_out     = hsync_d2_r;
  assign vsync_out     = vsync_d2_r;
  assign hblnk_out     = hblnk_d2_r;
  assign vblnk_out     = vblnk_d2_r;
  assign rgb_out       = rgb_d2_r;
  assign clr_busy      = clr_busy_r;
  assign lines_cleared = lines_r;

endmodule

// File: tb/tb_draw_board.sv
// Directed self-checking bench for draw_board.
module tb_draw_board;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = 12'h000;
  logic        set_en = 1'b0;
  logic [3:0]  set_col = 4'd0;
  logic [4:0]  set_row = 5'd0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        clr_busy;
  logic [7:0]  lines_cleared;

  int vectors = 0;
  int miscompares = 0;
  int cnt;
  logic [9:0] obs_board [20];
  logic [9:0] exp_board [20];

  draw_board dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .set_en(set_en), .set_col(set_col), .set_row(set_row),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .clr_busy(clr_busy), .lines_cleared(lines_cleared)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
  endtask

  task automatic set_cell(input int c, input int r);
    set_col = 4'(c); set_row = 5'(r); set_en = 1'b1;
    step();
    set_en = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    drive(x, y, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    step();
    step();
    chk(tag, 32'(rgb_out), 32'(exp));
  endtask

  // Probe the centre-ish pixel of every cell and compare each row word.
  task automatic check_board(input string tag);
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        drive(352 + 32 * c + 5, 64 + 32 * r + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        step();
        step();
        obs_board[r][c] = (rgb_out === 12'hF80);
      end
    end
    for (int r = 0; r < 20; r++) begin
      chk($sformatf("%s_row%0d", tag, r), 32'(obs_board[r]), 32'(exp_board[r]));
    end
  endtask

  // Raise vblank, count busy cycles, optionally inject a write while busy.
  task automatic run_clear(input int inject_k, output int busy);
    busy = 0;
    drive(400, 780, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123);
    for (int k = 0; k < 200; k++) begin
      step();
      set_en = 1'b0;
      if (k == inject_k) set_en = 1'b1;
      if (clr_busy) busy++;
      else if (busy > 0) break;
    end
    chk("vblank_rgb", 32'(rgb_out), 32'h000);
    vblnk_in = 1'b0;
    step();
  endtask

  initial begin
    for (int r = 0; r < 20; r++) exp_board[r] = 10'h000;

    // Reset state with busy inputs
    drive(500, 600, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
    step(); step();
    chk("rst_rgb", 32'(rgb_out), 32'h000);
    chk("rst_hcount", 32'(hcount_out), 32'h0);
    chk("rst_sync", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_lines", 32'(lines_cleared), 32'h0);
    rst = 1'b1;
    step();

    // Two-cycle pipeline on timing and colour
    drive(100, 200, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123); step();
    drive(101, 200, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123); step();
    chk("pipe_a_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        32'({11'd100, 11'd200, 4'b1000}));
    chk("pipe_a_rgb", 32'(rgb_out), 32'h123);
    drive(357, 677, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123); step();
    chk("pipe_b_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        32'({11'd101, 11'd200, 4'b0110}));
    chk("pipe_b_hblank_rgb", 32'(rgb_out), 32'h000);
    drive(671, 703, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC); step();
    chk("pipe_c_rgb_empty", 32'(rgb_out), 32'h123);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); step();
    chk("pipe_d_tim", 32'({hcount_out, vcount_out}), 32'({11'd671, 11'd703}));
    chk("pipe_d_rgb", 32'(rgb_out), 32'hABC);

    // Empty-board vblank: plain scan only
    run_clear(-1, cnt);
    chk("busy_empty", 32'(cnt), 32'd20);
    chk("lines_empty", 32'(lines_cleared), 32'd0);

    // Single cell rendering
    set_cell(0, 19);
    pix("cell_fill", 357, 677, 12'hF80);
    pix("cell_edge", 352, 672, 12'h444);
    pix("cell_next_col", 389, 677, 12'h123);
    pix("left_of_board", 351, 677, 12'h123);

    // One full row plus a cell above it
    for (int c = 0; c < 10; c++) set_cell(c, 19);
    set_cell(3, 18);
    run_clear(-1, cnt);
    chk("busy_one", 32'(cnt), 32'd22);
    chk("lines_one", 32'(lines_cleared), 32'd1);
    exp_board[19] = 10'h008;
    check_board("after_one");

    // Two full rows plus a cell above them
    for (int c = 0; c < 10; c++) begin
      set_cell(c, 18);
      set_cell(c, 19);
    end
    set_cell(5, 17);
    run_clear(-1, cnt);
    chk("busy_two", 32'(cnt), 32'd24);
    chk("lines_two", 32'(lines_cleared), 32'd3);
    exp_board[19] = 10'h020;
    check_board("after_two");

    // Out-of-range writes are ignored
    set_cell(10, 0);
    set_cell(0, 20);
    set_cell(15, 31);
    check_board("oor");

    // Write while busy is dropped
    set_col = 4'd2; set_row = 5'd2;
    run_clear(3, cnt);
    chk("busy_drop", 32'(cnt), 32'd20);
    chk("lines_drop", 32'(lines_cleared), 32'd3);
    check_board("drop");

    // Write on the same edge as the vblank rise is seen by the scan
    for (int c = 0; c < 9; c++) set_cell(c, 0);
    set_col = 4'd9; set_row = 5'd0; set_en = 1'b1;
    run_clear(-1, cnt);
    chk("busy_same", 32'(cnt), 32'd22);
    chk("lines_same", 32'(lines_cleared), 32'd4);
    check_board("same");

    // Reset in the middle of a shift
    for (int c = 0; c < 10; c++) set_cell(c, 19);
    drive(500, 780, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123);
    step();
    step();
    chk("shift_busy", 32'(clr_busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(clr_busy), 32'h0);
    chk("mid_rst_lines", 32'(lines_cleared), 32'h0);
    chk("mid_rst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    vblnk_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    exp_board[19] = 10'h000;
    check_board("post_rst");
    chk("post_rst_lines", 32'(lines_cleared), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_board.md
# draw_board

Pixel-pipeline stage between `draw_background` and `draw_rect`. It stores the settled-block playfield (COLS×ROWS cells), overlays occupied cells onto the background stream and forwards all timing signals with matched delay. During each vertical blanking interval it removes full rows and shifts the stack down. A game-control block writes lock-down cells through a single-cycle write port.

## Interface
- `BOARD_X`, 352: left pixel of board
- `BOARD_Y`, 64: top pixel of board
- `CELL_LOG2`, 5: cell edge = 2^CELL_LOG2 px (32)
- `COLS`, 10: board width in cells (≤16)
- `ROWS`, 20: board height in cells (≤32)
- `CELL_RGB`, 12'hF80: fill colour of occupied cell
- `EDGE_RGB`, 12'h444: colour of occupied cell's top row/left column pixels
- `pclk`  in  1  pixel clock (75 MHz); all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `hcount_in`, `vcount_in`  in  11  pixel counters from upstream
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1  sync/blank from upstream
- `rgb_in`  in  12  upstream colour {r,g,b}
- `set_en`  in  1  one-cycle strobe: mark cell occupied
- `set_col`  in  4  column of cell to set (0 = left)
- `set_row`  in  5  row of cell to set (0 = top)
- `hcount_out`, `vcount_out`  out  11  counters delayed 2 cycles
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1  delayed 2 cycles
- `rgb_out`  out  12  composited colour
- `clr_busy`  out  1  high while line-clear FSM is not IDLE
- `lines_cleared`  out  8  total rows removed since reset, wraps 255→0

## Operation
- Storage: ROWS registers of COLS bits; bit c of row r = cell (c,r). Reset: all zero.
- Write: `set_en` high, FSM IDLE, `set_col`<COLS, `set_row`<ROWS → bit set on that edge. Setting an occupied cell: no change. Out-of-range coordinates: ignored. `set_en` while `clr_busy`: dropped; the upstream controller must hold off.
- Render, stage 1: register inputs; compute `inside` = hcount in [BOARD_X, BOARD_X+COLS·2^CELL_LOG2) and vcount in [BOARD_Y, BOARD_Y+ROWS·2^CELL_LOG2); col = (hcount−BOARD_X)>>CELL_LOG2, row likewise; latch the indexed row word and the low CELL_LOG2 offset bits.
- Render, stage 2: hblnk|vblnk → 12'h000; else inside and cell bit set → EDGE_RGB if x-offset==0 or y-offset==0, else CELL_RGB; else the stage-1-delayed `rgb_in`.
- Line-clear FSM, states IDLE, SCAN, SHIFT:
  - IDLE→SCAN on the rising edge of `vblnk_in` (registered previous value 0, current 1); r := ROWS−1.
  - SCAN: row r all ones → SHIFT; else r==0 → IDLE; else r := r−1.
  - SHIFT, one cycle: rows r..1 take row above, row 0 := 0, `lines_cleared` += 1 → SCAN with the same r (the row shifted down is re-checked).
  - A vblnk rising edge while not IDLE is ignored.
- `set_en` and the vblnk rising edge in the same IDLE cycle: the write lands on that edge; the first SCAN cycle sees it.
- The board changes only during vblank, so no tearing in the visible frame.

## Timing
- All outputs are registered. All outputs reset to 0 asynchronously. Deasserting `rst` syncs to pclk for the first update.
- Pixel-path latency is exactly 2 cycles for every output. Counter and sync outputs equal the inputs from 2 cycles earlier.
- Write-to-display: a set cell is visible on any pixel sampled ≥1 cycle after the write edge.
- `clr_busy` rises 1 cycle after the detected vblnk edge. Its duration is ROWS scan cycles plus 2 cycles per cleared row: 20 cycles with no clears, 28 with 4 clears. This always fits inside vblank.
- Reset asserted mid-SCAN/SHIFT: FSM→IDLE, board cleared, counter 0, immediately.

## Test plan
- Reset, then run one frame with rgb_in=12'h123 → rgb_out=12'h123 on all visible pixels, 12'h000 in blanking, 2-cycle delay on all timing outputs.
- set (0,19) → pixel (357,677) = 12'hF80; (352,672) = 12'h444; (389,677) = rgb_in.
- Fill row 19 (cols 0–9) plus (3,18); pulse vblnk → clr_busy high 22 cycles, lines_cleared=1, only (3,19) set afterwards.
- Fill rows 18 and 19 fully plus (5,17) → lines_cleared +2, (5,19) set, rows 0–18 empty.
- set_en with (10,0) or row 20 → no change. set_en while clr_busy → dropped, board unchanged after FSM returns to IDLE.
- Assert rst during SHIFT → all outputs 0 immediately; after release, board empty and lines_cleared=0.
